// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: op encodings, FSM states, default
// latencies and the signed/unsigned divide helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    // Returns {remainder, quotient}; works on magnitudes so that the
    // most-negative dividend never overflows an intermediate.
    function automatic logic [63:0] mdu_divide(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        is_signed
    );
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
            quo = 32'd0;
            rem = 32'd0;
        end else begin
            quo = mag_a / mag_b;
            rem = mag_a % mag_b;
        end
        if (neg_a ^ neg_b) begin
            quo = 32'd0 - quo;
        end else begin
            quo = quo;
        end
        if (neg_a) begin
            rem = 32'd0 - rem;
        end else begin
            rem = rem;
        end
        return {rem, quo};
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Multi-cycle HI/LO sequencer: computes the result at launch, holds busy for
// the op latency, commits HI/LO as busy falls. MDU_CANCEL_EN adds a cancel port.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state_r;
    mdu_state_e       state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx_s;

    logic        busy_r;
    logic        busy_nx_s;
    logic [31:0] hi_r;
    logic [31:0] hi_nx_s;
    logic [31:0] lo_r;
    logic [31:0] lo_nx_s;
    logic [31:0] pend_hi_r;
    logic [31:0] pend_hi_nx_s;
    logic [31:0] pend_lo_r;
    logic [31:0] pend_lo_nx_s;
    logic        pend_wr_r;
    logic        pend_wr_nx_s;

    mdu_op_e     op_s;
    logic        cancel_s;
    logic        start_ok_s;
    logic        commit_s;
    logic        mul_signed_s;
    logic [63:0] prod_s;
    logic [63:0] div_s;

`ifdef MDU_CANCEL_EN
    assign cancel_s = cancel;
`else
    assign cancel_s = 1'b0;
`endif

    assign op_s       = mdu_op_e'(op);
    assign start_ok_s = start && !cancel_s && (state_r == ST_IDLE);
    assign commit_s   = (state_r != ST_IDLE) && !cancel_s && (cnt_r <= CNT_ONE);

    // One shared 64x64 multiplier; sign-extending the operands yields the signed low 64 bits.
    assign mul_signed_s = (op_s == OP_MULT);
    assign prod_s = {{32{mul_signed_s & rs_data[31]}}, rs_data}
                  * {{32{mul_signed_s & rt_data[31]}}, rt_data};
    assign div_s  = mdu_divide(rs_data, rt_data, op_s == OP_DIV);

    // FSM state and latency counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // FSM next-state and counter logic
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    case (op_s)
                        OP_MULT, OP_MULTU: begin
                            state_nx_s = ST_MUL;
                            cnt_nx_s   = CNT_MULT;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_nx_s = ST_DIV;
                            cnt_nx_s   = CNT_DIV;
                        end
                        default: begin
                            state_nx_s = ST_IDLE;
                            cnt_nx_s   = cnt_r;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = cnt_r;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cancel_s || (cnt_r <= CNT_ONE)) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = state_r;
                    cnt_nx_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // Output/datapath next values: launch captures pending result, commit copies it out
    always_comb begin
        hi_nx_s      = hi_r;
        lo_nx_s      = lo_r;
        pend_hi_nx_s = pend_hi_r;
        pend_lo_nx_s = pend_lo_r;
        pend_wr_nx_s = pend_wr_r;
        busy_nx_s    = (state_nx_s != ST_IDLE);
        if (commit_s && pend_wr_r) begin
            hi_nx_s = pend_hi_r;
            lo_nx_s = pend_lo_r;
        end else begin
            hi_nx_s = hi_r;
            lo_nx_s = lo_r;
        end
        if (start_ok_s) begin
            case (op_s)
                OP_MULT, OP_MULTU: begin
                    pend_hi_nx_s = prod_s[63:32];
                    pend_lo_nx_s = prod_s[31:0];
                    pend_wr_nx_s = 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    pend_hi_nx_s = div_s[63:32];
                    pend_lo_nx_s = div_s[31:0];
                    pend_wr_nx_s = (rt_data != 32'd0);
                end
                OP_MTHI: hi_nx_s = rs_data;
                OP_MTLO: lo_nx_s = rs_data;
                default: pend_wr_nx_s = pend_wr_r;
            endcase
        end else begin
            pend_wr_nx_s = pend_wr_r;
        end
    end

    // HI/LO, pending result and busy registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
        end else begin
            busy_r    <= busy_nx_s;
            hi_r      <= hi_nx_s;
            lo_r      <= lo_nx_s;
            pend_hi_r <= pend_hi_nx_s;
            pend_lo_r <= pend_lo_nx_s;
            pend_wr_r <= pend_wr_nx_s;
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer with hand-computed HI/LO
// values; define MDU_CANCEL_EN to also exercise the cancel port.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .rs_data(rs_data),
        .rt_data(rt_data),
`ifdef MDU_CANCEL_EN
        .cancel(cancel),
`endif
        .busy(busy),
        .hi(hi),
        .lo(lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        tick();
        start = 1'b0; op = 3'd0;
    endtask

    // Counts sampled busy cycles (bounded) and notes whether hi/lo moved meanwhile.
    task automatic wait_idle(output int cycles, output logic held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi; l0 = lo; cycles = 0; held = 1'b1;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; op = OP_MTHI; rs_data = 32'hDEADBEEF; rt_data = 32'd0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 00000000", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 00000000", lo); end
        start = 1'b0; op = 3'd0; reset = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int c; logic held;
        issue(OP_MULT, 32'hFFFFFFFF, 32'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_rise got %b want 1", busy); end
        wait_idle(c, held);
        checks++; if (c !== 5) begin errors++; $display("FAIL mult_busy_cycles got %0d want 5", c); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL mult_hold got %b want 1", held); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_result got %h_%h want ffffffff_fffffffe", hi, lo); end
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        wait_idle(c, held);
        checks++; if (c !== 5) begin errors++; $display("FAIL multu_busy_cycles got %0d want 5", c); end
        checks++; if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_result got %h_%h want 00000001_fffffffe", hi, lo); end
        issue(OP_MULT, 32'h80000000, 32'h80000000);
        wait_idle(c, held);
        checks++; if (hi !== 32'h40000000 || lo !== 32'h00000000) begin errors++; $display("FAIL mult_minneg got %h_%h want 40000000_00000000", hi, lo); end
        issue(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB);
        wait_idle(c, held);
        checks++; if (hi !== 32'h00000000 || lo !== 32'h0000000F) begin errors++; $display("FAIL mult_negneg got %h_%h want 00000000_0000000f", hi, lo); end
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(c, held);
        checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin errors++; $display("FAIL multu_max got %h_%h want fffffffe_00000001", hi, lo); end
    endtask

    task automatic test_div();
        int c; logic held;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy_rise got %b want 1", busy); end
        wait_idle(c, held);
        checks++; if (c !== 10) begin errors++; $display("FAIL div_busy_cycles got %0d want 10", c); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL div_hold got %b want 1", held); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_result got %h_%h want ffffffff_fffffffd", hi, lo); end
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_idle(c, held);
        checks++; if (c !== 10) begin errors++; $display("FAIL divzero_busy_cycles got %0d want 10", c); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL divzero_unchanged got %h_%h want ffffffff_fffffffd", hi, lo); end
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_idle(c, held);
        checks++; if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negdivisor got %h_%h want 00000001_fffffffd", hi, lo); end
        issue(OP_DIVU, 32'hFFFFFFFF, 32'h00000010);
        wait_idle(c, held);
        checks++; if (hi !== 32'h0000000F || lo !== 32'h0FFFFFFF) begin errors++; $display("FAIL divu_result got %h_%h want 0000000f_0fffffff", hi, lo); end
    endtask

    task automatic test_mtlo_while_busy();
        int c; logic held;
        issue(OP_MTHI, 32'hAAAA0000, 32'd0);
        issue(OP_MTLO, 32'h0000BBBB, 32'd0);
        checks++; if (busy !== 1'b0 || hi !== 32'hAAAA0000 || lo !== 32'h0000BBBB) begin errors++; $display("FAIL mthi_mtlo got busy=%b %h_%h want 0 aaaa0000_0000bbbb", busy, hi, lo); end
        issue(OP_MULT, 32'd3, 32'd5);
        tick();
        issue(OP_MTLO, 32'h12345678, 32'd0);
        checks++; if (busy !== 1'b1 || lo !== 32'h0000BBBB) begin errors++; $display("FAIL mtlo_ignored got busy=%b lo=%h want 1 0000bbbb", busy, lo); end
        wait_idle(c, held);
        checks++; if (c !== 3) begin errors++; $display("FAIL mtlo_busy_remaining got %0d want 3", c); end
        checks++; if (hi !== 32'h00000000 || lo !== 32'h0000000F) begin errors++; $display("FAIL mult_after_mtlo got %h_%h want 00000000_0000000f", hi, lo); end
        issue(OP_MTLO, 32'h12345678, 32'd0);
        checks++; if (busy !== 1'b0 || lo !== 32'h12345678 || hi !== 32'h00000000) begin errors++; $display("FAIL mtlo_after_busy got busy=%b %h_%h want 0 00000000_12345678", busy, hi, lo); end
    endtask

    task automatic test_back_to_back();
        int c; logic held;
        issue(OP_MULTU, 32'd2, 32'd3);
        wait_idle(c, held);
        issue(OP_DIVU, 32'd100, 32'd7);
        checks++; if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd6) begin errors++; $display("FAIL b2b_launch got busy=%b %h_%h want 1 00000000_00000006", busy, hi, lo); end
        wait_idle(c, held);
        checks++; if (c !== 10) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 10", c); end
        checks++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL b2b_result got %h_%h want 00000002_0000000e", hi, lo); end
    endtask

    task automatic test_nop();
        issue(OP_NOP, 32'h55555555, 32'd1);
        issue(OP_RSVD, 32'h55555555, 32'd1);
        checks++; if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL nop_ignored got busy=%b %h_%h want 0 00000002_0000000e", busy, hi, lo); end
    endtask

    task automatic test_reset_mid_div();
        issue(OP_DIV, 32'd100, 32'd7);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_mid_div got busy=%b %h_%h want 0 00000000_00000000", busy, hi, lo); end
        repeat (12) tick();
        checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL reset_no_commit got busy=%b %h_%h want 0 00000000_00000000", busy, hi, lo); end
    endtask

`ifdef MDU_CANCEL_EN
    task automatic test_cancel();
        issue(OP_MTHI, 32'h11111111, 32'd0);
        issue(OP_MTLO, 32'h22222222, 32'd0);
        issue(OP_MULT, 32'd3, 32'd5);
        cancel = 1'b1;
        issue(OP_MTHI, 32'hDEADBEEF, 32'd0);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin errors++; $display("FAIL cancel got busy=%b %h_%h want 0 11111111_22222222", busy, hi, lo); end
        repeat (8) tick();
        checks++; if (busy !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin errors++; $display("FAIL cancel_no_commit got busy=%b %h_%h want 0 11111111_22222222", busy, hi, lo); end
    endtask
`endif

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        test_reset();
        test_mult();
        test_div();
        test_mtlo_while_busy();
        test_back_to_back();
        test_nop();
        test_reset_mid_div();
`ifdef MDU_CANCEL_EN
        test_cancel();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: cycles busy is held for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: cycles busy is held for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: launch qualifier for op, sampled at the rising edge.
REQ-006 SHALL have port op, input, 3 bits: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
REQ-007 SHALL have port rs_data, input, 32 bits: operand A, or the MTHI/MTLO source.
REQ-008 SHALL have port rt_data, input, 32 bits: operand B.
REQ-009 SHALL have port busy, output, 1 bit: an operation is in flight; the stall controller stalls MDU-class instructions on (start | busy).
REQ-010 SHALL have port hi, output, 32 bits: architectural HI register.
REQ-011 SHALL have port lo, output, 32 bits: architectural LO register.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, plus a down-counter of width ceil(log2(max(MULT_CYCLES, DIV_CYCLES)+1)).
REQ-013 SHALL, in IDLE, when start=1 with op MULT/MULTU at edge N, compute the 64-bit product from that edge's operands into pending registers, enter MUL, and load the counter with MULT_CYCLES.
REQ-014 SHALL treat DIV/DIVU identically to REQ-013, but enter DIV and load the counter with DIV_CYCLES.
REQ-015 SHALL drive busy=1 exactly when state is not IDLE; busy rises at edge N and falls at edge N+latency, giving exactly latency cycles of busy.
REQ-016 SHALL commit hi/lo at the same edge at which busy falls; hi/lo SHALL hold their prior values throughout busy.
REQ-017 SHALL compute MULT as a signed 32x32 product and MULTU as unsigned, with {hi,lo}=product.
REQ-018 SHALL place the quotient in lo and the remainder in hi for DIV/DIVU; signed division truncates toward zero, and the remainder takes the sign of the dividend.
REQ-019 SHALL, on divide by zero (rt_data=0), still occupy DIV_CYCLES cycles and leave hi/lo unchanged.
REQ-020 SHALL, for MTHI/MTLO with start=1 in IDLE, write rs_data to hi/lo at that edge, with busy remaining 0.
REQ-021 SHALL ignore start while busy=1; the in-flight operation SHALL be unaffected.
REQ-022 SHALL permit start to be accepted in the first cycle after busy falls, with no bubble.
REQ-023 SHALL ignore start with op NOP or 7, leaving state unchanged.

Reset
REQ-024 SHALL, when reset=0 at a rising edge, set state=IDLE, counter=0, busy=0, hi=0, lo=0, and clear the pending registers; a reset during an operation SHALL abort it with no commit.
REQ-025 SHALL give reset priority over start and over any pending commit.

Configuration
REQ-026 SHALL, when macro MDU_CANCEL_EN is defined, add input port cancel (1 bit): cancel=1 while busy returns the FSM to IDLE at that edge, leaves hi/lo unchanged, and drops busy.
REQ-027 SHALL, under MDU_CANCEL_EN, ignore a start sampled in the same cycle as cancel=1, including MTHI/MTLO.
REQ-028 SHALL, when MDU_CANCEL_EN is undefined, have no cancel port and behave as REQ-012..REQ-025.

Structure
REQ-029 SHALL take the op encodings and the default latency constants from a shared package mdu_pkg, which the stall and forward controllers also use.
REQ-030 SHALL be a single module with no sub-modules; the arithmetic is one combinational stage registered at launch.

Verification
REQ-031 SHALL cover: MULT rs=0xFFFFFFFF, rt=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-032 SHALL cover: MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-033 SHALL cover: DIV rs=-7, rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU rs=7, rt=0 -> hi/lo unchanged after 10 cycles.
REQ-034 SHALL cover: MTLO 0x12345678 while busy from MULT -> ignored, and the MULT result commits; the same MTLO issued the cycle after busy falls -> lo=0x12345678 next edge.
REQ-035 SHALL cover: reset=0 at cycle 3 of DIV -> busy=0, hi=lo=0 next cycle, and no later commit.
REQ-036 SHALL cover, under MDU_CANCEL_EN: cancel at cycle 2 of MULT with start+MTHI in the same cycle -> busy=0, and hi/lo keep their pre-MULT values.
